// File: rtl/ecc_apb_ctrl.sv
// APB register bank and one-shot launch sequencer for the ECC datapath.
// Operands are snapshotted at launch; the result (or a timeout code) is held for the bus.
module ecc_apb_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       core_start,
  output logic [1:0]                 core_mode,
  output logic [1:0]                 core_width,
  output logic [DATA_WIDTH-1:0]      core_data,
  output logic [DATA_WIDTH-1:0]      core_noise,
  input  logic                       core_done,
  input  logic [DATA_WIDTH-1:0]      core_data_out,
  input  logic [1:0]                 core_num_of_errors,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  // Last WAIT cycle (T6) is the one where the counter holds 4.
  localparam logic [2:0] WAIT_LAST = 3'd4;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q;
  logic [1:0]              ctrl_q, width_q;
  logic [DATA_WIDTH-1:0]   data_in_q, noise_q;
  logic [1:0]              snap_mode_q, snap_width_q;
  logic [DATA_WIDTH-1:0]   snap_data_q, snap_noise_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [1:0]              errors_q;
  logic [AMBA_WORD-1:0]    prdata_q, rd_mux;

  logic                    addr_hit, wr_access, rd_setup;
  logic                    sel_ctrl, sel_data, sel_width, sel_noise;
  logic [1:0]              ctrl_mode;
  logic                    launch_ph, accept, timeout;

  assign addr_hit  = (PADDR[AMBA_ADDR_WIDTH-1:4] == '0);
  assign sel_ctrl  = addr_hit && (PADDR[3:0] == 4'h0);
  assign sel_data  = addr_hit && (PADDR[3:0] == 4'h4);
  assign sel_width = addr_hit && (PADDR[3:0] == 4'h8);
  assign sel_noise = addr_hit && (PADDR[3:0] == 4'hC);
  assign wr_access = PSEL && PENABLE && PWRITE;
  assign rd_setup  = PSEL && !PENABLE && !PWRITE;
  assign ctrl_mode = (ctrl_q == 2'b11) ? 2'b00 : ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      width_q   <= '0;
      data_in_q <= '0;
      noise_q   <= '0;
    end else if (wr_access) begin
      if (sel_ctrl)  ctrl_q    <= PWDATA[1:0];
      if (sel_data)  data_in_q <= PWDATA[DATA_WIDTH-1:0];
      if (sel_width) width_q   <= PWDATA[1:0];
      if (sel_noise) noise_q   <= PWDATA[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)       rd_mux[1:0]            = ctrl_q;
    else if (sel_data)  rd_mux[DATA_WIDTH-1:0] = data_in_q;
    else if (sel_width) rd_mux[1:0]            = width_q;
    else if (sel_noise) rd_mux[DATA_WIDTH-1:0] = noise_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          prdata_q <= '0;
    else if (rd_setup) prdata_q <= rd_mux;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state; CTRL writes outside IDLE update the register only
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (wr_access && sel_ctrl) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (core_done || (cnt_q == WAIT_LAST)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    launch_ph      = 1'b0;
    accept         = 1'b0;
    timeout        = 1'b0;
    operation_done = 1'b0;
    case (state_q)
      S_LAUNCH: launch_ph = 1'b1;
      S_WAIT: begin
        accept  = core_done;
        timeout = !core_done && (cnt_q == WAIT_LAST);
      end
      S_DONE:   operation_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt_q <= '0;
    else if (launch_ph)         cnt_q <= '0;
    else if (state_q == S_WAIT) cnt_q <= cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_mode_q  <= '0;
      snap_width_q <= '0;
      snap_data_q  <= '0;
      snap_noise_q <= '0;
    end else if (launch_ph) begin
      snap_mode_q  <= ctrl_mode;
      snap_width_q <= width_q;
      snap_data_q  <= data_in_q;
      snap_noise_q <= noise_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
      errors_q   <= '0;
    end else if (accept) begin
      data_out_q <= core_data_out;
      errors_q   <= core_num_of_errors;
    end else if (timeout) begin
      data_out_q <= '0;
      errors_q   <= 2'b11;
    end
  end

  // During LAUNCH the live registers are exactly what the snapshot is about to
  // capture, so the datapath sees valid operands alongside core_start.
  assign core_start    = launch_ph;
  assign core_mode     = launch_ph ? ctrl_mode : snap_mode_q;
  assign core_width    = launch_ph ? width_q   : snap_width_q;
  assign core_data     = launch_ph ? data_in_q : snap_data_q;
  assign core_noise    = launch_ph ? noise_q   : snap_noise_q;
  assign PRDATA        = prdata_q;
  assign data_out      = data_out_q;
  assign num_of_errors = errors_q;

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Scoreboard bench for ecc_apb_ctrl: randomized APB traffic, a behavioural core
// responder, and a monitor comparing reads, launches and results to a register model.
module tb_ecc_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA;
  logic        core_start;
  logic [1:0]  core_mode, core_width;
  logic [31:0] core_data, core_noise;
  logic        core_done;
  logic [31:0] core_data_out;
  logic [1:0]  core_num_of_errors;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        operation_done;

  ecc_apb_ctrl #(.DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA),
    .core_start(core_start), .core_mode(core_mode), .core_width(core_width),
    .core_data(core_data), .core_noise(core_noise), .core_done(core_done),
    .core_data_out(core_data_out), .core_num_of_errors(core_num_of_errors),
    .data_out(data_out), .num_of_errors(num_of_errors), .operation_done(operation_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int exp_starts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register model
  logic [1:0]  m_ctrl, m_width;
  logic [31:0] m_data, m_noise;
  logic [31:0] m_last;
  logic [1:0]  m_last_err;

  typedef struct {
    int          cyc;
    logic [31:0] dout;
    logic [1:0]  err;
  } done_t;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
    int          d;
    logic [31:0] rdata;
    logic [1:0]  rerr;
    bit          stray;
    logic [31:0] prev_out;
  } op_t;

  done_t       done_q[$];
  op_t         op_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [19:0] a);
    case (a)
      20'h0:   return {30'b0, m_ctrl};
      20'h4:   return m_data;
      20'h8:   return {30'b0, m_width};
      20'hC:   return m_noise;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [19:0] a, input logic [31:0] v);
    case (a)
      20'h0:   m_ctrl  = v[1:0];
      20'h4:   m_data  = v;
      20'h8:   m_width = v[1:0];
      20'hC:   m_noise = v;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_width = 0; m_data = 0; m_noise = 0; m_last = 0; m_last_err = 0;
  endtask

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic apb_write(input logic [19:0] a, input logic [31:0] v, output int t0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = v;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    model_write(a, v);
  endtask

  task automatic apb_read(input logic [19:0] a);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    rd_q.push_back(model_read(a));
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic launch(input logic [1:0] mode, input int d, input logic [31:0] rdat,
                        input logic [1:0] rerr, input bit stray, input bit exp_done);
    op_t   o;
    done_t e;
    int    t0;
    o.mode = (mode == 2'b11) ? 2'b00 : mode;
    o.width = m_width; o.data = m_data; o.noise = m_noise;
    o.d = d; o.rdata = rdat; o.rerr = rerr; o.stray = stray; o.prev_out = m_last;
    op_q.push_back(o);
    apb_write(20'h0, {30'b0, mode}, t0);
    exp_starts++;
    check("core_start_at_T1", {31'b0, core_start}, 32'h1);
    if (exp_done) begin
      e.cyc  = t0 + ((d == 0) ? 7 : d + 1);
      e.dout = (d == 0) ? 32'h0 : rdat;
      e.err  = (d == 0) ? 2'b11 : rerr;
      done_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (done_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got no operation_done expected one by cycle %0d", done_q[0].cyc);
      done_q.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
    check("data_out_hold", data_out, m_last);
    check("errors_hold", {30'b0, num_of_errors}, {30'b0, m_last_err});
  endtask

  // Monitor: results, read data and launch count
  always @(negedge clk) begin
    if (operation_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got operation_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        done_t e;
        e = done_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("data_out", data_out, e.dout);
        check("num_of_errors", {30'b0, num_of_errors}, {30'b0, e.err});
        m_last = e.dout;
        m_last_err = e.err;
      end
    end
    if (PSEL && PENABLE && !PWRITE) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: got %h expected no read", PRDATA);
      end else begin
        check("prdata", PRDATA, rd_q.pop_front());
      end
    end
    if (core_start) starts++;
  end

  // Behavioural datapath: answers each launch after the scheduled delay
  initial begin
    core_done = 1'b0; core_data_out = '0; core_num_of_errors = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_start: got core_start=1 expected 0 (cycle %0d)", cyc);
        end else begin
          op_t o;
          o = op_q.pop_front();
          check("snap_mode", {30'b0, core_mode}, {30'b0, o.mode});
          check("snap_width", {30'b0, core_width}, {30'b0, o.width});
          check("snap_data", core_data, o.data);
          check("snap_noise", core_noise, o.noise);
          check("data_out_kept_on_launch", data_out, o.prev_out);
          if (o.d != 0) begin
            repeat (o.d - 1) @(posedge clk);
            #1;
            core_done = 1'b1; core_data_out = o.rdata; core_num_of_errors = o.rerr;
            @(posedge clk); #1;
            core_done = 1'b0;
            check("snap_data_stable", core_data, o.data);
            check("snap_noise_stable", core_noise, o.noise);
          end else if (o.stray) begin
            // Pulse in DONE and IDLE; both must be ignored.
            repeat (6) @(posedge clk);
            #1;
            core_done = 1'b1; core_data_out = $urandom; core_num_of_errors = 2'b10;
            repeat (2) @(posedge clk);
            #1;
            core_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          k, r, idx;
    logic [19:0] a;
    logic [19:0] rd_addrs[6];

    rd_addrs[0] = 20'h0; rd_addrs[1] = 20'h4; rd_addrs[2] = 20'h8;
    rd_addrs[3] = 20'hC; rd_addrs[4] = 20'h10; rd_addrs[5] = 20'h3;
    rst = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_errors", {30'b0, num_of_errors}, 32'h0);
    check("rst_done", {31'b0, operation_done}, 32'h0);
    check("rst_start", {31'b0, core_start}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) apb_read(rd_addrs[i]);

    // Encode, core answers at T3
    apb_write(20'h4, 32'h0000_00A5, t);
    apb_write(20'h8, 32'h0, t);
    launch(2'b00, 3, 32'h0000_03A5, 2'b00, 1'b0, 1'b1);
    wait_idle();

    // Full mode, late answer, DATA_IN rewritten at T2
    apb_write(20'hC, 32'h4, t);
    launch(2'b10, 6, $urandom, 2'b01, 1'b0, 1'b1);
    apb_write(20'h4, 32'hDEAD_BEEF, t);
    wait_idle();

    // Timeout with stray core_done afterwards
    launch(2'b01, 0, 32'h1234_5678, 2'b00, 1'b1, 1'b1);
    wait_idle();

    // CTRL rewritten during WAIT: no relaunch, new value readable
    launch(2'b01, 4, $urandom, 2'b10, 1'b0, 1'b1);
    apb_write(20'h0, 32'h2, t);
    wait_idle();
    apb_read(20'h0);

    // CTRL=11 runs as encode
    launch(2'b11, 2, $urandom, 2'b00, 1'b0, 1'b1);
    wait_idle();
    launch(2'b00, 5, $urandom, 2'b01, 1'b0, 1'b1);
    wait_idle();

    // Register readback, masked widths, dropped unmapped write
    apb_write(20'h8, 32'hFFFF_FFFE, t);
    apb_write(20'hC, 32'hCAFE_F00D, t);
    apb_write(20'h10, 32'hFFFF_FFFF, t);
    for (int i = 0; i < 6; i++) apb_read(rd_addrs[i]);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      for (int w = 0; w < k; w++) begin
        idx = $urandom_range(1, 5);
        a = rd_addrs[idx];
        apb_write(a, $urandom, t);
      end
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 5);
        apb_read(rd_addrs[idx]);
      end
      r = $urandom_range(0, 5);
      launch(2'($urandom_range(0, 2)), (r == 0) ? 0 : r + 1, $urandom,
             2'($urandom_range(0, 3)), (r == 0), 1'b1);
      wait_idle();
    end

    // Reset in the middle of WAIT abandons the operation
    apb_write(20'h4, 32'h5555_AAAA, t);
    launch(2'b10, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_errors", {30'b0, num_of_errors}, 32'h0);
    check("mid_rst_done", {31'b0, operation_done}, 32'h0);
    check("mid_rst_core_data", core_data, 32'h0);
    check("mid_rst_core_mode", {30'b0, core_mode}, 32'h0);
    check("mid_rst_prdata", PRDATA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) apb_read(rd_addrs[i]);
    repeat (4) begin @(posedge clk); #1; end

    check("launch_count", starts, exp_starts);
    check("pending_ops", op_q.size(), 0);
    check("pending_reads", rd_q.size(), 0);
    check("pending_dones", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
